// File: rtl/pkt_rr_sched_if.sv
// pkt_rr_sched_if: bundles the per-source FIFO read ports, the output byte
// stream and the status signals of pkt_rr_sched.
//   master : scheduler side (pops sources, drives the output stream)
//   slave  : environment side (source FIFOs, consumer, status observer)
// Source i occupies src_data[8i+7:8i] and bit i of every N-wide vector.
interface pkt_rr_sched_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned NW = 3
);
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_empty;
  logic [N-1:0]   src_rd_ena;
  logic [N-1:0]   src_mask;
  logic [7:0]     out_data;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic [NW-1:0]  grant_id;
  logic           pkt_done;
  logic [NW-1:0]  pkt_src;

  modport master (
    input  src_data, src_last, src_empty, src_mask, out_ready,
    output src_rd_ena, out_data, out_last, out_valid, busy, grant_id, pkt_done, pkt_src
  );

  modport slave (
    output src_data, src_last, src_empty, src_mask, out_ready,
    input  src_rd_ena, out_data, out_last, out_valid, busy, grant_id, pkt_done, pkt_src
  );
endinterface

// File: rtl/pkt_rr_sched.sv
// pkt_rr_sched: packet-granular round-robin scheduler. Drains up to N packet
// FIFOs into one registered byte stream without interleaving packets.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   io_bus : pkt_rr_sched_if.master (source read ports, output stream, status)
module pkt_rr_sched #(
  parameter int unsigned N  = 4,
  parameter int unsigned NW = 3
) (
  input logic             i_clk,
  input logic             i_rst,
  pkt_rr_sched_if.master  io_bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  logic [0:0]    r_state;
  logic [NW-1:0] r_grant;
  logic [7:0]    r_out_data;
  logic          r_out_last;
  logic          r_out_valid;
  logic [NW-1:0] r_pkt_src;

  logic [N-1:0]  w_req;
  logic [NW-1:0] w_pick;
  logic          w_found;
  logic [7:0]    w_head_data;
  logic          w_head_last;
  logic          w_head_empty;
  logic          w_pop;
  logic          w_done;
  logic [N-1:0]  w_rd_ena;

  assign w_req = ~io_bus.src_empty & io_bus.src_mask;

  // Round-robin search starting at grant+1, wrapping modulo N (not 2^NW) so
  // the grant index can never leave 0..N-1. off==N revisits the last grant.
  always_comb begin
    w_pick  = r_grant;
    w_found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!w_found && w_req[i] && (i == (32'(r_grant) + off) % N)) begin
          w_pick  = NW'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  // Head of the granted source.
  always_comb begin
    w_head_data  = '0;
    w_head_last  = 1'b0;
    w_head_empty = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_grant == NW'(i)) begin
        w_head_data  = io_bus.src_data[8*i +: 8];
        w_head_last  = io_bus.src_last[i];
        w_head_empty = io_bus.src_empty[i];
      end
    end
  end

  // Pop whenever the output register is free or being drained this cycle.
  assign w_pop  = (r_state == StXfer) && !w_head_empty && (!r_out_valid || io_bus.out_ready);
  assign w_done = w_pop && w_head_last;

  always_comb begin
    w_rd_ena = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_rd_ena[i] = w_pop && (r_grant == NW'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_grant <= NW'(N - 1);
    end else if (r_state == StIdle) begin
      if (w_found) begin
        r_grant <= w_pick;
        r_state <= StXfer;
      end
    end else if (w_done) begin
      r_state <= StIdle;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_data  <= w_head_data;
      r_out_last  <= w_head_last;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pkt_src <= '0;
    end else if (w_done) begin
      r_pkt_src <= r_grant;
    end
  end

  assign io_bus.src_rd_ena = w_rd_ena;
  assign io_bus.out_data   = r_out_data;
  assign io_bus.out_last   = r_out_last;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.busy       = (r_state == StXfer);
  assign io_bus.grant_id   = r_grant;
  assign io_bus.pkt_done   = w_done;
  // pkt_done is same-cycle as the pop, so pkt_src bypasses the register then.
  assign io_bus.pkt_src    = w_done ? r_grant : r_pkt_src;

endmodule

// File: tb/tb_pkt_rr_sched.sv
module tb_pkt_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_rr_sched_if #(.N(4), .NW(3)) bus4 ();
  pkt_rr_sched_if #(.N(3), .NW(2)) bus3 ();

  pkt_rr_sched #(.N(4), .NW(3)) dut4 (.i_clk(clk), .i_rst(rst), .io_bus(bus4));
  pkt_rr_sched #(.N(3), .NW(2)) dut3 (.i_clk(clk), .i_rst(rst), .io_bus(bus3));

  int total = 0;
  int bad   = 0;

  // Source FIFO model for the N=4 instance.
  logic [7:0] fd [4][64];
  logic       fl [4][64];
  int         wp [4];
  int         rp [4];

  always_comb begin
    bus4.src_empty = '1;
    bus4.src_data  = '0;
    bus4.src_last  = '0;
    for (int i = 0; i < 4; i++) begin
      bus4.src_empty[i]      = (rp[i] == wp[i]);
      bus4.src_data[8*i +: 8] = fd[i][rp[i]];
      bus4.src_last[i]       = fl[i][rp[i]];
    end
  end

  // Monitor.
  int         cyc = 0;
  int         pop_cnt = 0;
  int         onehot_err = 0;
  int         stab_err = 0;
  int         err3 = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d = '0;
  logic       hold_l = 1'b0;
  logic [7:0] acc_d [$];
  logic       acc_l [$];
  int         acc_c [$];
  int         done_q [$];
  int         q3 [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (bus4.src_rd_ena[i]) rp[i] <= rp[i] + 1;
    end
    if (bus4.src_rd_ena != '0) pop_cnt <= pop_cnt + 1;
    if ($countones(bus4.src_rd_ena) > 1) onehot_err <= onehot_err + 1;
    if (bus4.out_valid && bus4.out_ready) begin
      acc_d.push_back(bus4.out_data);
      acc_l.push_back(bus4.out_last);
      acc_c.push_back(cyc);
    end
    if (bus4.pkt_done) done_q.push_back(int'(bus4.pkt_src));
    if (hold && !(bus4.out_valid && bus4.out_data == hold_d && bus4.out_last == hold_l))
      stab_err <= stab_err + 1;
    hold   <= bus4.out_valid && !bus4.out_ready;
    hold_d <= bus4.out_data;
    hold_l <= bus4.out_last;
    if (bus3.pkt_done) q3.push_back(int'(bus3.pkt_src));
    if (bus3.grant_id > 2'd2) err3 <= err3 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [7:0] b, input logic l);
    fd[s][wp[s]] = b;
    fl[s][wp[s]] = l;
    wp[s] = wp[s] + 1;
  endtask

  task automatic clear_logs();
    acc_d.delete();
    acc_l.delete();
    acc_c.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus4.out_valid); end
    total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus4.busy); end
    total++; if (bus4.src_rd_ena !== 4'b0) begin bad++; $display("FAIL reset_rd_ena got=%b exp=0000", bus4.src_rd_ena); end
    total++; if (bus4.grant_id !== 3'd3) begin bad++; $display("FAIL reset_grant got=%0d exp=3", bus4.grant_id); end
    total++; if (bus4.pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done got=%0b exp=0", bus4.pkt_done); end
    total++; if (bus4.pkt_src !== 3'd0) begin bad++; $display("FAIL reset_pkt_src got=%0d exp=0", bus4.pkt_src); end
    total++; if (bus4.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus4.out_data); end
    total++; if (bus4.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b exp=0", bus4.out_last); end
    total++; if (bus3.grant_id !== 2'd2) begin bad++; $display("FAIL reset_grant_n3 got=%0d exp=2", bus3.grant_id); end
    rst = 1'b0;
    tick();
    total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", bus4.busy); end
  endtask

  task automatic test_single();
    clear_logs();
    push(0, 8'hAA, 1'b0);
    push(0, 8'hBB, 1'b0);
    push(0, 8'hCC, 1'b1);
    tick();
    total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", bus4.busy); end
    total++; if (bus4.grant_id !== 3'd0) begin bad++; $display("FAIL single_grant got=%0d exp=0", bus4.grant_id); end
    total++; if (bus4.src_rd_ena !== 4'b0001) begin bad++; $display("FAIL single_rd_ena got=%b exp=0001", bus4.src_rd_ena); end
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_c1 got=%0b exp=0", bus4.out_valid); end
    tick();
    total++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'hAA || bus4.out_last !== 1'b0) begin
      bad++; $display("FAIL single_byte0 got=%0b/%h/%0b exp=1/aa/0", bus4.out_valid, bus4.out_data, bus4.out_last); end
    tick();
    total++; if (bus4.out_data !== 8'hBB || bus4.out_last !== 1'b0) begin
      bad++; $display("FAIL single_byte1 got=%h/%0b exp=bb/0", bus4.out_data, bus4.out_last); end
    total++; if (bus4.pkt_done !== 1'b1 || bus4.pkt_src !== 3'd0) begin
      bad++; $display("FAIL single_done got=%0b/%0d exp=1/0", bus4.pkt_done, bus4.pkt_src); end
    tick();
    total++; if (bus4.out_data !== 8'hCC || bus4.out_last !== 1'b1) begin
      bad++; $display("FAIL single_byte2 got=%h/%0b exp=cc/1", bus4.out_data, bus4.out_last); end
    total++; if (bus4.busy !== 1'b0 || bus4.pkt_done !== 1'b0) begin
      bad++; $display("FAIL single_after_busy got=%0b/%0b exp=0/0", bus4.busy, bus4.pkt_done); end
    tick();
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b exp=0", bus4.out_valid); end
    total++; if (acc_d.size() != 3 || done_q.size() != 1) begin
      bad++; $display("FAIL single_counts got=%0d/%0d exp=3/1", acc_d.size(), done_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0] eb;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++) begin
        push(s, 8'(s * 16 + 2 * p + 1), 1'b0);
        push(s, 8'(s * 16 + 2 * p + 2), 1'b1);
      end
    end
    for (int c = 0; c < 100 && acc_d.size() < 16; c++) tick();
    tick();
    total++; if (acc_d.size() != 16 || done_q.size() != 8) begin
      bad++; $display("FAIL rr_counts got=%0d/%0d exp=16/8", acc_d.size(), done_q.size()); end
    if (acc_d.size() == 16 && done_q.size() == 8) begin
      for (int k = 0; k < 16; k++) begin
        eb = 8'(((k / 2) % 4) * 16 + 2 * (k / 8) + (k % 2) + 1);
        total++; if (acc_d[k] !== eb || acc_l[k] !== 1'(k % 2)) begin
          bad++; $display("FAIL rr_byte%0d got=%h/%0b exp=%h/%0b", k, acc_d[k], acc_l[k], eb, k % 2); end
        if (k > 0) begin
          total++; if (acc_c[k] - acc_c[k-1] != ((k % 2 == 1) ? 1 : 2)) begin
            bad++; $display("FAIL rr_gap%0d got=%0d exp=%0d", k, acc_c[k] - acc_c[k-1], (k % 2 == 1) ? 1 : 2); end
        end
      end
      for (int k = 0; k < 8; k++) begin
        total++; if (done_q[k] != k % 4) begin
          bad++; $display("FAIL rr_src%0d got=%0d exp=%0d", k, done_q[k], k % 4); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int p0, s0, o0;
    clear_logs();
    p0 = pop_cnt; s0 = stab_err; o0 = onehot_err;
    for (int k = 0; k < 5; k++) push(1, 8'(8'h51 + k), (k == 4));
    for (int c = 0; c < 60 && acc_d.size() < 5; c++) begin
      bus4.out_ready = pat[c % 4];
      tick();
    end
    bus4.out_ready = 1'b1;
    repeat (2) tick();
    total++; if (acc_d.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", acc_d.size()); end
    if (acc_d.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        total++; if (acc_d[k] !== 8'(8'h51 + k) || acc_l[k] !== (k == 4)) begin
          bad++; $display("FAIL bp_byte%0d got=%h/%0b exp=%h/%0b", k, acc_d[k], acc_l[k], 8'h51 + k, k == 4); end
      end
    end
    total++; if (pop_cnt - p0 != 5) begin bad++; $display("FAIL bp_pops got=%0d exp=5", pop_cnt - p0); end
    total++; if (stab_err - s0 != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err - s0); end
    total++; if (onehot_err - o0 != 0) begin bad++; $display("FAIL bp_onehot got=%0d exp=0", onehot_err - o0); end
  endtask

  task automatic test_mask();
    clear_logs();
    bus4.src_mask = 4'b1101;
    for (int k = 0; k < 3; k++) push(1, 8'(8'h61 + k), (k == 2));
    for (int k = 0; k < 3; k++) push(2, 8'(8'h71 + k), (k == 2));
    tick();
    total++; if (bus4.grant_id !== 3'd2 || bus4.busy !== 1'b1) begin
      bad++; $display("FAIL mask_grant got=%0d/%0b exp=2/1", bus4.grant_id, bus4.busy); end
    bus4.src_mask = 4'b1001;
    for (int c = 0; c < 20 && acc_d.size() < 3; c++) tick();
    repeat (8) tick();
    total++; if (done_q.size() != 1 || acc_d.size() != 3) begin
      bad++; $display("FAIL mask_complete got=%0d/%0d exp=1/3", done_q.size(), acc_d.size()); end
    else begin
      total++; if (done_q[0] != 2 || acc_d[2] !== 8'h73) begin
        bad++; $display("FAIL mask_src got=%0d/%h exp=2/73", done_q[0], acc_d[2]); end
    end
    total++; if (bus4.busy !== 1'b0 || bus4.grant_id !== 3'd2 || wp[1] - rp[1] != 3) begin
      bad++; $display("FAIL mask_blocked got=%0b/%0d/%0d exp=0/2/3", bus4.busy, bus4.grant_id, wp[1] - rp[1]); end
    bus4.src_mask = 4'b1111;
    for (int c = 0; c < 20 && done_q.size() < 2; c++) tick();
    total++; if (done_q.size() != 2) begin bad++; $display("FAIL mask_restore_count got=%0d exp=2", done_q.size()); end
    else begin
      total++; if (done_q[1] != 1) begin bad++; $display("FAIL mask_restore_src got=%0d exp=1", done_q[1]); end
    end
    repeat (2) tick();
  endtask

  task automatic test_n3();
    q3.delete();
    bus3.src_empty = 3'b010;
    repeat (16) tick();
    bus3.src_empty = 3'b111;
    repeat (3) tick();
    total++; if (q3.size() < 4) begin bad++; $display("FAIL n3_count got=%0d exp>=4", q3.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (q3[k] != ((k % 2 == 0) ? 0 : 2)) begin
          bad++; $display("FAIL n3_src%0d got=%0d exp=%0d", k, q3[k], (k % 2 == 0) ? 0 : 2); end
      end
    end
    total++; if (err3 != 0) begin bad++; $display("FAIL n3_grant_range got=%0d exp=0", err3); end
  endtask

  task automatic test_async_rst();
    clear_logs();
    for (int k = 0; k < 6; k++) push(3, 8'(8'h81 + k), (k == 5));
    repeat (3) tick();
    total++; if (bus4.out_data !== 8'h82 || bus4.out_valid !== 1'b1) begin
      bad++; $display("FAIL arst_pre got=%h/%0b exp=82/1", bus4.out_data, bus4.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.src_rd_ena !== 4'b0) begin
      bad++; $display("FAIL arst_now got=%0b/%0b/%b exp=0/0/0000", bus4.out_valid, bus4.busy, bus4.src_rd_ena); end
    total++; if (bus4.grant_id !== 3'd3) begin bad++; $display("FAIL arst_grant got=%0d exp=3", bus4.grant_id); end
    tick();
    rst = 1'b0;
    total++; if (wp[3] - rp[3] != 4) begin bad++; $display("FAIL arst_left got=%0d exp=4", wp[3] - rp[3]); end
    push(0, 8'h91, 1'b1);
    tick();
    total++; if (bus4.grant_id !== 3'd0) begin bad++; $display("FAIL arst_regrant got=%0d exp=0", bus4.grant_id); end
    repeat (20) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      for (int j = 0; j < 64; j++) begin
        fd[i][j] = '0;
        fl[i][j] = 1'b0;
      end
    end
    bus4.src_mask  = 4'b1111;
    bus4.out_ready = 1'b1;
    bus3.src_data  = 24'h332211;
    bus3.src_last  = 3'b111;
    bus3.src_empty = 3'b111;
    bus3.src_mask  = 3'b111;
    bus3.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_n3();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
